// File: rtl/match_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : match_controller_if
// Description : Control/status bundle between the game logic and the match
//               sequencer. The master side (game logic) raises goal levels
//               and start/clear requests. The slave side (match_controller)
//               returns scores, the field-reset pulse, the freeze flag and
//               the match result.
//   goal_in     master->slave  NUM_TEAMS          ball inside goal of team i
//   start       master->slave  1                  kick-off request (1 cycle)
//   clear       master->slave  1                  zero scores, back to idle
//   scores      slave->master  NUM_TEAMS*SCORE_W  team i at [i*SCORE_W +: SCORE_W]
//   reset_field slave->master  1                  1-cycle re-centre pulse
//   freeze      slave->master  1                  players/ball use step 0
//   match_over  slave->master  1                  match finished
//   winner      slave->master  WINNER_W           winning team index
// Revision    : 1.0 - initial release
// ============================================================================
interface match_controller_if #(
    parameter int NUM_TEAMS = 2,
    parameter int SCORE_W   = 4,
    parameter int WINNER_W  = (NUM_TEAMS > 1) ? $clog2(NUM_TEAMS) : 1
);
    logic [NUM_TEAMS-1:0]         goal_in;
    logic                         start;
    logic                         clear;
    logic [NUM_TEAMS*SCORE_W-1:0] scores;
    logic                         reset_field;
    logic                         freeze;
    logic                         match_over;
    logic [WINNER_W-1:0]          winner;

    modport master (
        output goal_in, start, clear,
        input  scores, reset_field, freeze, match_over, winner
    );

    modport slave (
        input  goal_in, start, clear,
        output scores, reset_field, freeze, match_over, winner
    );
endinterface
`default_nettype wire

// File: rtl/match_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : match_controller
// Description : Match/score sequencer for the soccer game. Counts goals for
//               NUM_TEAMS teams and walks through idle, play, post-goal pause
//               and match-over. Drives the field-reset pulse and the freeze
//               flag that gates player/ball steps.
// Ports       :
//   Clk        in   system clock
//   Reset_n    in   asynchronous active-low reset
//   frame_clk  in   vsync, asynchronous to Clk; each rising edge is a frame
//   bus        slave modport of match_controller_if (goal_in, start, clear,
//              scores, reset_field, freeze, match_over, winner)
// Revision    : 1.0 - initial release
// ============================================================================
module match_controller #(
    parameter int NUM_TEAMS    = 2,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 5,
    parameter int PAUSE_FRAMES = 60,
    parameter int PAUSE_W      = 8
) (
    input  wire                 Clk,
    input  wire                 Reset_n,
    input  wire                 frame_clk,
    match_controller_if.slave   bus
);

    localparam int c_winner_w = (NUM_TEAMS > 1) ? $clog2(NUM_TEAMS) : 1;
    localparam logic [SCORE_W-1:0] c_score_max = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] c_win_score = SCORE_W'(WIN_SCORE);
    localparam logic [PAUSE_W-1:0] c_pause_len = PAUSE_W'(PAUSE_FRAMES);
    localparam logic [PAUSE_W-1:0] c_pause_one = PAUSE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t                              r_state;
    logic [NUM_TEAMS-1:0][SCORE_W-1:0]   r_scores;
    logic [PAUSE_W-1:0]                  r_pause_cnt;
    logic [c_winner_w-1:0]               r_winner;
    logic                                r_reset_field;
    logic                                r_freeze;
    logic                                r_match_over;

    logic [1:0]                          r_frame_sync;
    logic                                r_frame_prev;
    logic                                r_frame_tick;
    logic [NUM_TEAMS-1:0]                r_goal_prev;
    logic [NUM_TEAMS-1:0]                r_goal_ev;

    logic                                w_goal_any;
    logic [c_winner_w-1:0]               w_goal_idx;
    logic [SCORE_W-1:0]                  w_score_sel;
    logic [SCORE_W-1:0]                  w_score_inc;

    // Frame edge detection runs on synchronised vsync; the tick is registered
    // so it lands three Clk edges after the vsync rise. Goal events are also
    // registered, which gives two cycles from goal_in rise to score update.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_frame_sync <= 2'b00;
            r_frame_prev <= 1'b0;
            r_frame_tick <= 1'b0;
            r_goal_prev  <= '0;
            r_goal_ev    <= '0;
        end else begin
            r_frame_sync <= {r_frame_sync[0], frame_clk};
            r_frame_prev <= r_frame_sync[1];
            r_frame_tick <= r_frame_sync[1] & ~r_frame_prev;
            r_goal_prev  <= bus.goal_in;
            r_goal_ev    <= bus.goal_in & ~r_goal_prev;
        end
    end

    // Lowest-index goal wins when several rise in the same cycle.
    always_comb begin
        w_goal_any = |r_goal_ev;
        w_goal_idx = '0;
        for (int i = NUM_TEAMS - 1; i >= 0; i--) begin
            if (r_goal_ev[i]) begin
                w_goal_idx = c_winner_w'(i);
            end
        end
    end

    assign w_score_sel = r_scores[w_goal_idx];
    assign w_score_inc = (w_score_sel == c_score_max) ? w_score_sel
                                                      : w_score_sel + 1'b1;

    // Sequencer. freeze/match_over are registered alongside the state so they
    // change on the same edge as the transition that implies them.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= S_IDLE;
            r_scores      <= '0;
            r_pause_cnt   <= '0;
            r_winner      <= '0;
            r_reset_field <= 1'b0;
            r_freeze      <= 1'b1;
            r_match_over  <= 1'b0;
        end else begin
            r_reset_field <= 1'b0;
            if (bus.clear) begin
                r_state      <= S_IDLE;
                r_scores     <= '0;
                r_pause_cnt  <= '0;
                r_winner     <= '0;
                r_freeze     <= 1'b1;
                r_match_over <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state       <= S_PLAY;
                            r_freeze      <= 1'b0;
                            r_reset_field <= 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (w_goal_any) begin
                            r_scores[w_goal_idx] <= w_score_inc;
                            r_freeze             <= 1'b1;
                            if (w_score_inc == c_win_score) begin
                                r_winner     <= w_goal_idx;
                                r_state      <= S_OVER;
                                r_match_over <= 1'b1;
                            end else begin
                                r_pause_cnt <= c_pause_len;
                                r_state     <= S_PAUSE;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (r_frame_tick) begin
                            if (r_pause_cnt == c_pause_one) begin
                                r_state       <= S_PLAY;
                                r_freeze      <= 1'b0;
                                r_reset_field <= 1'b1;
                            end else begin
                                r_pause_cnt <= r_pause_cnt - 1'b1;
                            end
                        end
                    end
                    S_OVER: begin
                        if (bus.start) begin
                            r_scores      <= '0;
                            r_winner      <= '0;
                            r_state       <= S_PLAY;
                            r_freeze      <= 1'b0;
                            r_match_over  <= 1'b0;
                            r_reset_field <= 1'b1;
                        end
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_freeze     <= 1'b1;
                        r_match_over <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.scores      = r_scores;
    assign bus.reset_field = r_reset_field;
    assign bus.freeze      = r_freeze;
    assign bus.match_over  = r_match_over;
    assign bus.winner      = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_match_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_match_controller
// Description : Self-checking bench for match_controller. Two instances: a
//               2-team default build and a 4-team build with 2-bit scores.
//               A behavioural match model predicts every output each cycle;
//               directed sequences add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_match_controller;

    localparam int NT_A = 2, SW_A = 4, WIN_A = 5, PF_A = 60, PW_A = 8;
    localparam int NT_B = 4, SW_B = 2, WIN_B = 3, PF_B = 4,  PW_B = 3;

    localparam int P_NT  [2] = '{NT_A, NT_B};
    localparam int P_SW  [2] = '{SW_A, SW_B};
    localparam int P_WIN [2] = '{WIN_A, WIN_B};
    localparam int P_PF  [2] = '{PF_A, PF_B};

    localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_OVER = 3;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic frame_a = 1'b0;
    logic frame_b = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    match_controller_if #(.NUM_TEAMS(NT_A), .SCORE_W(SW_A)) if_a ();
    match_controller_if #(.NUM_TEAMS(NT_B), .SCORE_W(SW_B)) if_b ();

    match_controller #(
        .NUM_TEAMS(NT_A), .SCORE_W(SW_A), .WIN_SCORE(WIN_A),
        .PAUSE_FRAMES(PF_A), .PAUSE_W(PW_A)
    ) dut_a (
        .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_a), .bus(if_a)
    );

    match_controller #(
        .NUM_TEAMS(NT_B), .SCORE_W(SW_B), .WIN_SCORE(WIN_B),
        .PAUSE_FRAMES(PF_B), .PAUSE_W(PW_B)
    ) dut_b (
        .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_b), .bus(if_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural match model ----------------
    int         m_mode  [2];
    int         m_sc    [2][4];
    int         m_win   [2];
    int         m_left  [2];   // frames still to wait in the post-goal pause
    logic       m_rf    [2];
    logic [3:0] m_gprev [2];
    logic [3:0] m_gev   [2];
    logic       m_fprev [2];
    logic [2:0] m_tdly  [2];   // frame rise seen at a Clk edge acts 3 edges later

    task automatic model_reset(input int d);
        m_mode[d] = M_IDLE;
        for (int t = 0; t < 4; t++) m_sc[d][t] = 0;
        m_win[d]   = 0;
        m_left[d]  = 0;
        m_rf[d]    = 1'b0;
        m_gprev[d] = 4'b0;
        m_gev[d]   = 4'b0;
        m_fprev[d] = 1'b0;
        m_tdly[d]  = 3'b0;
    endtask

    task automatic model_edge(input int d, input logic [3:0] goal, input logic st,
                              input logic cl, input logic fr);
        logic [3:0] ev;
        logic       tick;
        int         smax;
        int         t;
        ev   = m_gev[d];
        tick = m_tdly[d][2];
        m_gev[d]   = goal & ~m_gprev[d];
        m_gprev[d] = goal;
        m_tdly[d]  = {m_tdly[d][1:0], fr & ~m_fprev[d]};
        m_fprev[d] = fr;
        m_rf[d]    = 1'b0;
        smax       = (1 << P_SW[d]) - 1;
        if (cl) begin
            for (int k = 0; k < 4; k++) m_sc[d][k] = 0;
            m_win[d]  = 0;
            m_left[d] = 0;
            m_mode[d] = M_IDLE;
        end else if (m_mode[d] == M_IDLE) begin
            if (st) begin
                m_mode[d] = M_PLAY;
                m_rf[d]   = 1'b1;
            end
        end else if (m_mode[d] == M_PLAY) begin
            if (ev != 4'b0) begin
                t = 0;
                while (!ev[t]) t++;
                m_sc[d][t] = (m_sc[d][t] < smax) ? m_sc[d][t] + 1 : smax;
                if (m_sc[d][t] == P_WIN[d]) begin
                    m_win[d]  = t;
                    m_mode[d] = M_OVER;
                end else begin
                    m_left[d] = P_PF[d];
                    m_mode[d] = M_PAUSE;
                end
            end
        end else if (m_mode[d] == M_PAUSE) begin
            if (tick) begin
                m_left[d] = m_left[d] - 1;
                if (m_left[d] == 0) begin
                    m_mode[d] = M_PLAY;
                    m_rf[d]   = 1'b1;
                end
            end
        end else begin
            if (st) begin
                for (int k = 0; k < 4; k++) m_sc[d][k] = 0;
                m_win[d]  = 0;
                m_mode[d] = M_PLAY;
                m_rf[d]   = 1'b1;
            end
        end
    endtask

    // {scores[7:0], reset_field, freeze, match_over, winner[1:0]}
    function automatic logic [12:0] model_out(input int d);
        int         s;
        logic [1:0] w;
        s = 0;
        for (int t = 0; t < P_NT[d]; t++) s = s + (m_sc[d][t] << (t * P_SW[d]));
        w = 2'(m_win[d]);
        return {s[7:0], m_rf[d], (m_mode[d] != M_PLAY), (m_mode[d] == M_OVER), w};
    endfunction

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset(0);
                model_reset(1);
            end else begin
                model_edge(0, {2'b00, if_a.goal_in}, if_a.start, if_a.clear, frame_a);
                model_edge(1, if_b.goal_in, if_b.start, if_b.clear, frame_b);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("cycle_a", 32'({if_a.scores, if_a.reset_field, if_a.freeze,
                                if_a.match_over, 1'b0, if_a.winner}), 32'(model_out(0)));
            chk("cycle_b", 32'({if_b.scores, if_b.reset_field, if_b.freeze,
                                if_b.match_over, if_b.winner}), 32'(model_out(1)));
        end
    end

    // vsync generators: random period, phase offset keeps edges off Clk edges.
    initial begin
        forever begin
            repeat ($urandom_range(2, 5)) @(posedge clk);
            #(1.3 + real'($urandom_range(0, 7)));
            frame_a = ~frame_a;
        end
    end

    initial begin
        forever begin
            repeat ($urandom_range(2, 5)) @(posedge clk);
            #(1.3 + real'($urandom_range(0, 7)));
            frame_b = ~frame_b;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic goal_a(input logic [1:0] g);
        @(negedge clk);
        if_a.goal_in = g;
        repeat (3) @(negedge clk);
        if_a.goal_in = 2'b00;
    endtask

    task automatic goal_b(input logic [3:0] g);
        @(negedge clk);
        if_b.goal_in = g;
        repeat (3) @(negedge clk);
        if_b.goal_in = 4'b0;
    endtask

    task automatic wait_resume_a(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (if_a.reset_field) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_resume_b(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (if_b.reset_field) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic saw_rf;
        if_a.goal_in = '0; if_a.start = 1'b0; if_a.clear = 1'b0;
        if_b.goal_in = '0; if_b.start = 1'b0; if_b.clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state_a", 32'({if_a.scores, if_a.reset_field, if_a.freeze, if_a.match_over, if_a.winner}),
            32'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // kick-off
        pulse_start_a();
        chk("kick_rf", 32'(if_a.reset_field), 32'd1);
        chk("kick_freeze", 32'(if_a.freeze), 32'd0);
        chk("kick_scores", 32'(if_a.scores), 32'h00);
        @(negedge clk);
        chk("kick_rf_low", 32'(if_a.reset_field), 32'd0);

        // long goal level counts once, then a 60-frame pause
        @(negedge clk);
        if_a.goal_in = 2'b10;
        repeat (100) @(negedge clk);
        chk("goal_once", 32'(if_a.scores), 32'h10);
        chk("goal_freeze", 32'(if_a.freeze), 32'd1);
        if_a.goal_in = 2'b00;
        wait_resume_a("pause_end_rf");
        chk("pause_end_freeze", 32'(if_a.freeze), 32'd0);

        // simultaneous goals: lowest index credited
        goal_a(2'b11);
        chk("simul_goal", 32'(if_a.scores), 32'h11);
        chk("simul_pause", 32'(if_a.freeze), 32'd1);
        wait_resume_a("simul_resume");

        // team0 up to 4, then the winning goal
        for (int k = 0; k < 3; k++) begin
            goal_a(2'b01);
            wait_resume_a("climb_resume");
        end
        chk("pre_win", 32'(if_a.scores), 32'h14);
        goal_a(2'b01);
        chk("win_score", 32'(if_a.scores), 32'h15);
        chk("win_over", 32'(if_a.match_over), 32'd1);
        chk("win_winner", 32'(if_a.winner), 32'd0);
        goal_a(2'b10);
        chk("over_hold", 32'(if_a.scores), 32'h15);
        pulse_start_a();
        chk("restart_scores", 32'(if_a.scores), 32'h00);
        chk("restart_rf", 32'(if_a.reset_field), 32'd1);
        chk("restart_over", 32'(if_a.match_over), 32'd0);

        // clear mid-pause
        goal_a(2'b01);
        repeat (30) @(posedge frame_a);
        @(negedge clk);
        if_a.clear = 1'b1;
        @(negedge clk);
        if_a.clear = 1'b0;
        chk("clear_scores", 32'(if_a.scores), 32'h00);
        chk("clear_freeze", 32'(if_a.freeze), 32'd1);
        chk("clear_rf", 32'(if_a.reset_field), 32'd0);
        saw_rf = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (if_a.reset_field) saw_rf = 1'b1;
        end
        chk("clear_no_rf", 32'(saw_rf), 32'd0);

        // team1 wins, then async reset in OVER
        pulse_start_a();
        for (int k = 0; k < 5; k++) begin
            goal_a(2'b10);
            if (k < 4) wait_resume_a("t1_resume");
        end
        chk("t1_over", 32'(if_a.match_over), 32'd1);
        chk("t1_winner", 32'(if_a.winner), 32'd1);
        chk("t1_scores", 32'(if_a.scores), 32'h50);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({if_a.scores, if_a.reset_field, if_a.freeze, if_a.match_over, if_a.winner}),
            32'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4-team build: team3 wins
        @(negedge clk);
        if_b.start = 1'b1;
        @(negedge clk);
        if_b.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            goal_b(4'b1000);
            if (k < 2) wait_resume_b("b_resume");
        end
        chk("b_scores", 32'(if_b.scores), 32'hC0);
        chk("b_over", 32'(if_b.match_over), 32'd1);
        chk("b_winner", 32'(if_b.winner), 32'd3);

        // clear beats start
        @(negedge clk);
        if_b.start = 1'b1;
        if_b.clear = 1'b1;
        @(negedge clk);
        if_b.start = 1'b0;
        if_b.clear = 1'b0;
        chk("clear_over_start", 32'({if_b.scores, if_b.reset_field, if_b.freeze, if_b.match_over}),
            32'({8'h00, 1'b0, 1'b1, 1'b0}));

        // randomized traffic on both builds
        fork
            begin
                for (int c = 0; c < 12000; c++) begin
                    @(negedge clk);
                    if ($urandom_range(0, 9) == 0)
                        if_a.goal_in = ($urandom_range(0, 1) == 1) ? 2'($urandom) : 2'b00;
                    if_a.start = ($urandom_range(0, 29) == 0);
                    if_a.clear = ($urandom_range(0, 599) == 0);
                end
            end
            begin
                for (int c = 0; c < 12000; c++) begin
                    @(negedge clk);
                    if ($urandom_range(0, 7) == 0)
                        if_b.goal_in = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
                    if_b.start = ($urandom_range(0, 19) == 0);
                    if_b.clear = ($urandom_range(0, 399) == 0);
                end
            end
        join

        @(negedge clk);
        if_a.goal_in = '0; if_a.start = 1'b0; if_a.clear = 1'b0;
        if_b.goal_in = '0; if_b.start = 1'b0; if_b.clear = 1'b0;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
